// File: rtl/pipe_host_ctrl.sv
// Host command sequencer for the 5-stage pipeline access port.
// Serialises memory, register-file and ILA accesses and bounded RUNs; one response per command.
module pipe_host_ctrl #(
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned ILA_DEPTH_LOG2 = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_op,
    input  logic [8:0]                cmd_addr,
    input  logic [31:0]               cmd_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_data,
    input  logic                      halt,
    output logic                      pipe_en,
    output logic [31:0]               imem_data,
    output logic [8:0]                imem_addr,
    output logic                      imem_we,
    output logic                      imem_re,
    output logic [31:0]               dmem_data,
    output logic [7:0]                dmem_addr,
    output logic                      dmem_we_external,
    output logic                      dmem_re_external,
    output logic                      reg_re,
    output logic [3:0]                reg_addr,
    output logic [ILA_DEPTH_LOG2-1:0] ilaaddr,
    output logic [ILA_DEPTH_LOG2-1:0] ila2addr,
    output logic                      ilawea,
    output logic                      ila2wea,
    input  logic [31:0]               imem_out,
    input  logic [31:0]               dmem_out,
    input  logic [31:0]               reg_out,
    input  logic [31:0]               ila_out,
    input  logic [31:0]               ila2_out,
    input  logic                      N,
    input  logic                      Z,
    input  logic                      C,
    input  logic                      V
);

    localparam int unsigned DW  = 32;
    localparam int unsigned IAW = 9;
    localparam int unsigned DAW = 8;
    localparam int unsigned RAW = 4;
    localparam int unsigned PW  = ILA_DEPTH_LOG2;
    localparam int unsigned RCW = $clog2(RD_LAT + 2);

    typedef enum logic [2:0] {
        OP_IMEM_WR = 3'd0,
        OP_IMEM_RD = 3'd1,
        OP_DMEM_WR = 3'd2,
        OP_DMEM_RD = 3'd3,
        OP_REG_RD  = 3'd4,
        OP_ILA_RD  = 3'd5,
        OP_RUN     = 3'd6,
        OP_STATUS  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_RUN  = 3'd3,
        ST_RSP  = 3'd4
    } state_e;

    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic [IAW-1:0] addr_q, addr_d;
    logic [DW-1:0]  data_q, data_d;
    logic           arm_q, arm_d;
    logic [DW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  issued_q, issued_d;
    logic [RCW-1:0] rd_cnt_q, rd_cnt_d;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [DW-1:0]  rsp_data_q, rsp_data_d;
    logic [DW-1:0]  rd_sel;

    // Output registers, loaded with the decode of the upcoming state.
    logic           cmd_ready_q, cmd_ready_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           pipe_en_q, pipe_en_d;
    logic           ila_we_q, ila_we_d;
    logic           imem_we_q, imem_we_d;
    logic           imem_re_q, imem_re_d;
    logic           dmem_we_q, dmem_we_d;
    logic           dmem_re_q, dmem_re_d;
    logic           reg_re_q, reg_re_d;
    logic [IAW-1:0] imem_addr_q, imem_addr_d;
    logic [DW-1:0]  imem_data_q, imem_data_d;
    logic [DAW-1:0] dmem_addr_q, dmem_addr_d;
    logic [DW-1:0]  dmem_data_q, dmem_data_d;
    logic [RAW-1:0] reg_addr_q, reg_addr_d;
    logic [PW-1:0]  ila_addr_q, ila_addr_d;

    // Read-data source for the latched read op.
    always_comb begin
        rd_sel = ila_out;
        case (op_q)
            OP_IMEM_RD: rd_sel = imem_out;
            OP_DMEM_RD: rd_sel = dmem_out;
            OP_REG_RD:  rd_sel = reg_out;
            default:    rd_sel = data_q[0] ? ila2_out : ila_out;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        arm_d       = arm_q;
        cnt_d       = cnt_q;
        issued_d    = issued_q;
        rd_cnt_d    = rd_cnt_q;
        wptr_d      = wptr_q;
        rsp_data_d  = rsp_data_q;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        pipe_en_d   = 1'b0;
        ila_we_d    = 1'b0;
        imem_we_d   = 1'b0;
        imem_re_d   = 1'b0;
        dmem_we_d   = 1'b0;
        dmem_re_d   = 1'b0;
        reg_re_d    = 1'b0;
        imem_addr_d = '0;
        imem_data_d = '0;
        dmem_addr_d = '0;
        dmem_data_d = '0;
        reg_addr_d  = '0;
        ila_addr_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d   = op_e'(cmd_op);
                    addr_d = cmd_addr;
                    data_d = cmd_data;
                    case (op_e'(cmd_op))
                        OP_IMEM_WR, OP_DMEM_WR: state_d = ST_WR;
                        OP_IMEM_RD, OP_DMEM_RD, OP_REG_RD, OP_ILA_RD: begin
                            state_d  = ST_RD;
                            rd_cnt_d = '0;
                        end
                        OP_RUN: begin
                            arm_d    = cmd_addr[0];
                            cnt_d    = cmd_data;
                            issued_d = '0;
                            if (cmd_addr[0]) begin
                                wptr_d = '0;
                            end
                            if (cmd_data != '0) begin
                                state_d = ST_RUN;
                            end else begin
                                state_d    = ST_RSP;
                                rsp_data_d = '0;
                            end
                        end
                        default: begin
                            state_d    = ST_RSP;
                            rsp_data_d = {N, Z, C, V, (DW-4)'(wptr_q)};
                        end
                    endcase
                end
            end
            ST_WR: begin
                state_d    = ST_RSP;
                rsp_data_d = '0;
            end
            ST_RD: begin
                if (rd_cnt_q == RCW'(RD_LAT)) begin
                    state_d    = ST_RSP;
                    rsp_data_d = rd_sel;
                end else begin
                    rd_cnt_d = rd_cnt_q + RCW'(1);
                end
            end
            ST_RUN: begin
                // A sampled halt suppresses this cycle's pipe_en and ends the run.
                if (halt) begin
                    state_d    = ST_RSP;
                    rsp_data_d = issued_q;
                end else begin
                    issued_d = issued_q + DW'(1);
                    cnt_d    = cnt_q - DW'(1);
                    if (arm_q) begin
                        wptr_d = wptr_q + PW'(1);
                    end
                    if (cnt_q == DW'(1)) begin
                        state_d    = ST_RSP;
                        rsp_data_d = issued_q + DW'(1);
                    end
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d    = ST_IDLE;
                    rsp_data_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Port drive for the next cycle, decoded from the next state.
        case (state_d)
            ST_IDLE: cmd_ready_d = 1'b1;
            ST_RSP:  rsp_valid_d = 1'b1;
            ST_WR: begin
                if (op_d == OP_IMEM_WR) begin
                    imem_we_d   = 1'b1;
                    imem_addr_d = addr_d;
                    imem_data_d = data_d;
                end else begin
                    dmem_we_d   = 1'b1;
                    dmem_addr_d = addr_d[DAW-1:0];
                    dmem_data_d = data_d;
                end
            end
            ST_RD: begin
                case (op_d)
                    OP_IMEM_RD: begin
                        imem_re_d   = 1'b1;
                        imem_addr_d = addr_d;
                    end
                    OP_DMEM_RD: begin
                        dmem_re_d   = 1'b1;
                        dmem_addr_d = addr_d[DAW-1:0];
                    end
                    OP_REG_RD: begin
                        reg_re_d   = 1'b1;
                        reg_addr_d = addr_d[RAW-1:0];
                    end
                    default: ila_addr_d = PW'(addr_d);
                endcase
            end
            ST_RUN: begin
                pipe_en_d = 1'b1;
                if (arm_d) begin
                    ila_we_d   = 1'b1;
                    ila_addr_d = wptr_d;
                end
            end
            default: cmd_ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_IMEM_WR;
            addr_q      <= '0;
            data_q      <= '0;
            arm_q       <= 1'b0;
            cnt_q       <= '0;
            issued_q    <= '0;
            rd_cnt_q    <= '0;
            wptr_q      <= '0;
            rsp_data_q  <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            pipe_en_q   <= 1'b0;
            ila_we_q    <= 1'b0;
            imem_we_q   <= 1'b0;
            imem_re_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            dmem_re_q   <= 1'b0;
            reg_re_q    <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            dmem_addr_q <= '0;
            dmem_data_q <= '0;
            reg_addr_q  <= '0;
            ila_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            arm_q       <= arm_d;
            cnt_q       <= cnt_d;
            issued_q    <= issued_d;
            rd_cnt_q    <= rd_cnt_d;
            wptr_q      <= wptr_d;
            rsp_data_q  <= rsp_data_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            pipe_en_q   <= pipe_en_d;
            ila_we_q    <= ila_we_d;
            imem_we_q   <= imem_we_d;
            imem_re_q   <= imem_re_d;
            dmem_we_q   <= dmem_we_d;
            dmem_re_q   <= dmem_re_d;
            reg_re_q    <= reg_re_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            dmem_addr_q <= dmem_addr_d;
            dmem_data_q <= dmem_data_d;
            reg_addr_q  <= reg_addr_d;
            ila_addr_q  <= ila_addr_d;
        end
    end

    // Halt gates the run enables within the same cycle it is seen.
    assign pipe_en          = pipe_en_q & ~halt;
    assign ilawea           = ila_we_q & ~halt;
    assign ila2wea          = ila_we_q & ~halt;
    assign cmd_ready        = cmd_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_data         = rsp_data_q;
    assign imem_we          = imem_we_q;
    assign imem_re          = imem_re_q;
    assign imem_addr        = imem_addr_q;
    assign imem_data        = imem_data_q;
    assign dmem_we_external = dmem_we_q;
    assign dmem_re_external = dmem_re_q;
    assign dmem_addr        = dmem_addr_q;
    assign dmem_data        = dmem_data_q;
    assign reg_re           = reg_re_q;
    assign reg_addr         = reg_addr_q;
    assign ilaaddr          = ila_addr_q;
    assign ila2addr         = ila_addr_q;

endmodule

// File: tb/tb_pipe_host_ctrl.sv
// Directed bench for pipe_host_ctrl with simple memory/ILA stand-ins around the port.
module tb_pipe_host_ctrl;

    localparam int unsigned RD_LAT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [8:0]  cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        halt = 1'b0;
    logic        pipe_en;
    logic [31:0] imem_data;
    logic [8:0]  imem_addr;
    logic        imem_we, imem_re;
    logic [31:0] dmem_data;
    logic [7:0]  dmem_addr;
    logic        dmem_we_external, dmem_re_external;
    logic        reg_re;
    logic [3:0]  reg_addr;
    logic [8:0]  ilaaddr, ila2addr;
    logic        ilawea, ila2wea;
    logic [31:0] imem_out = '0, dmem_out = '0, reg_out = '0, ila_out = '0, ila2_out = '0;
    logic        N = 1'b1, Z = 1'b0, C = 1'b1, V = 1'b0;

    always #5 clk = ~clk;

    pipe_host_ctrl #(.RD_LAT(RD_LAT), .ILA_DEPTH_LOG2(9)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .halt(halt), .pipe_en(pipe_en),
        .imem_data(imem_data), .imem_addr(imem_addr), .imem_we(imem_we), .imem_re(imem_re),
        .dmem_data(dmem_data), .dmem_addr(dmem_addr),
        .dmem_we_external(dmem_we_external), .dmem_re_external(dmem_re_external),
        .reg_re(reg_re), .reg_addr(reg_addr),
        .ilaaddr(ilaaddr), .ila2addr(ila2addr), .ilawea(ilawea), .ila2wea(ila2wea),
        .imem_out(imem_out), .dmem_out(dmem_out), .reg_out(reg_out),
        .ila_out(ila_out), .ila2_out(ila2_out),
        .N(N), .Z(Z), .C(C), .V(V)
    );

    // One-cycle-latency memory stand-ins.
    logic [31:0] imem_mem [512];
    logic [31:0] dmem_mem [256];
    always @(posedge clk) begin
        if (imem_we) imem_mem[imem_addr] <= imem_data;
        if (imem_re) imem_out <= imem_mem[imem_addr];
        if (dmem_we_external) dmem_mem[dmem_addr] <= dmem_data;
        if (dmem_re_external) dmem_out <= dmem_mem[dmem_addr];
        if (reg_re) reg_out <= 32'h0000_0100 | 32'(reg_addr);
        ila_out  <= 32'hA5A5_0000 | 32'(ilaaddr);
        ila2_out <= 32'h5A5A_0000 | 32'(ila2addr);
    end

    int          pe_cnt = 0, imem_we_cnt = 0, ila_we_cnt = 0, excl_viol = 0, ila_addr_err = 0;
    int          ila_base = 0;
    logic [8:0]  last_imem_addr = '0;
    logic [7:0]  last_dmem_addr = '0;

    // Per-cycle observation of enables and the ILA write pointer sequence.
    always @(negedge clk) begin
        int mem_en;
        mem_en = int'(imem_we) + int'(imem_re) + int'(dmem_we_external)
               + int'(dmem_re_external) + int'(reg_re);
        if (mem_en > 1 || (pipe_en && mem_en != 0)) excl_viol++;
        if (pipe_en) pe_cnt++;
        if (imem_we) begin
            imem_we_cnt++;
            last_imem_addr = imem_addr;
        end
        if (dmem_we_external) last_dmem_addr = dmem_addr;
        if (ilawea) begin
            if (ilaaddr != 9'(ila_we_cnt - ila_base) || ila2addr != ilaaddr || !ila2wea)
                ila_addr_err++;
            ila_we_cnt++;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command from IDLE, return accept-to-response latency and payload, then consume.
    task automatic do_cmd(input logic [2:0] op, input logic [8:0] addr, input logic [31:0] data,
                          output int lat, output logic [31:0] rsp);
        if (op == 3'd6 && addr[0]) ila_base = ila_we_cnt;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_valid = 1'b1;
        lat       = 0;
        do begin
            tick();
            cmd_valid = 1'b0;
            lat++;
        end while (!rsp_valid && lat < 2000);
        rsp       = rsp_data;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    int          lat, pe0, iw0, w0;
    logic [31:0] rsp;

    initial begin
        repeat (2) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_pipe_en", 32'(pipe_en), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Instruction memory write / readback
        pe0 = pe_cnt;
        w0  = imem_we_cnt;
        do_cmd(3'd0, 9'h005, 32'hE3A0_1001, lat, rsp);
        check("imem_wr_lat", 32'(lat), 32'd2);
        check("imem_wr_rsp", rsp, 32'd0);
        check("imem_we_pulses", 32'(imem_we_cnt - w0), 32'd1);
        check("imem_we_addr", 32'(last_imem_addr), 32'd5);
        do_cmd(3'd1, 9'h005, 32'd0, lat, rsp);
        check("imem_rd_lat", 32'(lat), 32'(RD_LAT + 2));
        check("imem_rd_rsp", rsp, 32'hE3A0_1001);
        check("imem_no_pipe_en", 32'(pe_cnt - pe0), 32'd0);

        // Data memory, register file, ILA readback
        do_cmd(3'd2, 9'h1FF, 32'hDEAD_BEEF, lat, rsp);
        check("dmem_wr_lat", 32'(lat), 32'd2);
        check("dmem_wr_addr", 32'(last_dmem_addr), 32'h0000_00FF);
        do_cmd(3'd3, 9'h0FF, 32'd0, lat, rsp);
        check("dmem_rd_lat", 32'(lat), 32'(RD_LAT + 2));
        check("dmem_rd_rsp", rsp, 32'hDEAD_BEEF);
        do_cmd(3'd4, 9'h03C, 32'd0, lat, rsp);
        check("reg_rd_rsp", rsp, 32'h0000_010C);
        do_cmd(3'd5, 9'h003, 32'd0, lat, rsp);
        check("ila_rd_rsp", rsp, 32'hA5A5_0003);
        do_cmd(3'd5, 9'h007, 32'd1, lat, rsp);
        check("ila2_rd_rsp", rsp, 32'h5A5A_0007);
        check("ila_rd_lat", 32'(lat), 32'(RD_LAT + 2));

        // Armed RUN of 10
        pe0 = pe_cnt;
        iw0 = ila_we_cnt;
        do_cmd(3'd6, 9'h001, 32'd10, lat, rsp);
        check("run10_lat", 32'(lat), 32'd11);
        check("run10_rsp", rsp, 32'd10);
        check("run10_pipe_en", 32'(pe_cnt - pe0), 32'd10);
        check("run10_ila_we", 32'(ila_we_cnt - iw0), 32'd10);
        do_cmd(3'd7, 9'h000, 32'd0, lat, rsp);
        check("status_lat", 32'(lat), 32'd1);
        check("status_rsp10", rsp, 32'hA000_000A);

        // RUN 1000 halted on its 4th cycle
        pe0       = pe_cnt;
        ila_base  = ila_we_cnt;
        cmd_op    = 3'd6;
        cmd_addr  = 9'h001;
        cmd_data  = 32'd1000;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        halt = 1'b1;
        #1;
        check("halt_pipe_en", 32'(pipe_en), 32'd0);
        check("halt_ilawea", 32'(ilawea | ila2wea), 32'd0);
        tick();
        halt = 1'b0;
        check("halt_rsp_valid", 32'(rsp_valid), 32'd1);
        check("halt_rsp", rsp_data, 32'd3);
        check("halt_pipe_cnt", 32'(pe_cnt - pe0), 32'd3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Pointer wrap, unarmed run, zero-count run
        do_cmd(3'd6, 9'h001, 32'd600, lat, rsp);
        check("run600_lat", 32'(lat), 32'd601);
        check("run600_rsp", rsp, 32'd600);
        do_cmd(3'd7, 9'h000, 32'd0, lat, rsp);
        check("status_wrap", rsp, 32'hA000_0058);
        iw0 = ila_we_cnt;
        do_cmd(3'd6, 9'h000, 32'd5, lat, rsp);
        check("run5_rsp", rsp, 32'd5);
        check("run5_no_ila_we", 32'(ila_we_cnt - iw0), 32'd0);
        do_cmd(3'd7, 9'h000, 32'd0, lat, rsp);
        check("status_unarmed", rsp, 32'hA000_0058);
        pe0 = pe_cnt;
        do_cmd(3'd6, 9'h000, 32'd0, lat, rsp);
        check("run0_lat", 32'(lat), 32'd1);
        check("run0_rsp", rsp, 32'd0);
        check("run0_pipe_en", 32'(pe_cnt - pe0), 32'd0);

        // Response backpressure
        cmd_op    = 3'd7;
        cmd_addr  = 9'h000;
        cmd_data  = 32'd0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("bp_first_valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data", rsp_data, 32'hA000_0058);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_release_ready", 32'(cmd_ready), 32'd1);
        check("bp_release_valid", 32'(rsp_valid), 32'd0);

        // Reset in the middle of a RUN
        cmd_op    = 3'd6;
        cmd_addr  = 9'h000;
        cmd_data  = 32'd100;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("mid_run_pipe_en", 32'(pipe_en), 32'd1);
        reset = 1'b1;
        tick();
        check("rst_run_pipe_en", 32'(pipe_en), 32'd0);
        check("rst_run_cmd_ready", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_run_ready_after", 32'(cmd_ready), 32'd1);
        pe0 = pe_cnt;
        repeat (5) tick();
        check("rst_run_no_rsp", 32'(rsp_valid), 32'd0);
        check("rst_run_no_pipe_en", 32'(pe_cnt - pe0), 32'd0);
        do_cmd(3'd7, 9'h000, 32'd0, lat, rsp);
        check("status_after_rst", rsp, 32'hA000_0000);

        check("mutual_exclusion", 32'(excl_viol), 32'd0);
        check("ila_addr_sequence", 32'(ila_addr_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
